eth_packet_source: RTL and testbench

- Generates test Ethernet payload packets as a byte stream on a valid/ready interface with sop/eop framing.
- Drives the write side of the packet buffer; each port maps directly onto the buffer's wr_* inputs.
- Configured per run: packet length, packet count, inter-packet gap and payload pattern.
- Honours backpressure and reports progress counters.

---
 rtl/eth_pkt_pkg.sv | 30 +++
 rtl/eth_packet_source_if.sv | 15 +
 rtl/eth_lfsr8.sv | 23 ++
 rtl/eth_packet_source.sv | 210 +++++++++++++++++++++
 tb/tb_eth_packet_source.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkt_pkg.sv
// Shared types and constants for the Ethernet test-packet source.
package eth_pkt_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [MODE_W-1:0] MODE_INC   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_FIXED = 2'b01;
    localparam logic [MODE_W-1:0] MODE_LFSR  = 2'b10;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1; all-zero would lock the LFSR
    localparam logic [BYTE_W-1:0] LFSR_TAPS     = 8'hB8;
    localparam logic [BYTE_W-1:0] LFSR_ZERO_SUB = 8'h01;

    function automatic logic [BYTE_W-1:0] lfsr_next(input logic [BYTE_W-1:0] v);
        return {v[BYTE_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [BYTE_W-1:0] lfsr_seed(input logic [BYTE_W-1:0] s);
        return (s == '0) ? LFSR_ZERO_SUB : s;
    endfunction

endpackage

// File: rtl/eth_packet_source_if.sv
// Byte-stream handshake with sop/eop framing towards the packet buffer write side.
interface eth_packet_source_if;

    logic [eth_pkt_pkg::BYTE_W-1:0] tx_data;
    logic                           tx_valid;
    logic                           tx_sop;
    logic                           tx_eop;
    logic                           tx_ready;

    modport master (output tx_data, output tx_valid, output tx_sop, output tx_eop,
                    input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, input  tx_sop, input  tx_eop,
                    output tx_ready);

endinterface

// File: rtl/eth_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and per-transfer advance.
module eth_lfsr8
    import eth_pkt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BYTE_W-1:0] seed,
    input  logic              advance,
    output logic [BYTE_W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_ZERO_SUB;
        end else if (load) begin
            value <= lfsr_seed(seed);
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/eth_packet_source.sv
// Test packet generator: configurable length, count, gap and payload pattern,
// honouring sink backpressure and counting completed packets.
module eth_packet_source
    import eth_pkt_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned GAP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    input  logic [MODE_W-1:0]    cfg_mode,
    input  logic [BYTE_W-1:0]    cfg_seed,
    eth_packet_source_if.master  tx,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_error,
    output logic [CNT_WIDTH-1:0] pkt_sent
);

    state_t               state_q, state_n;
    logic [BYTE_W-1:0]    data_q, data_n;
    logic                 valid_q, valid_n, sop_q, sop_n, eop_q, eop_n;
    logic                 busy_q, busy_n, done_q, done_n, err_q, err_n;
    logic [CNT_WIDTH-1:0] sent_q, sent_n, count_q, count_n;
    logic [LEN_WIDTH-1:0] idx_q, idx_n, len_q, len_n;
    logic [GAP_WIDTH-1:0] gap_q, gap_n, gap_cnt_q, gap_cnt_n;
    logic [MODE_W-1:0]    mode_q, mode_n, mode_in;
    logic [BYTE_W-1:0]    seed_q, seed_n;
    logic                 abort_q, abort_n;
    logic                 lfsr_load, lfsr_adv;
    logic [BYTE_W-1:0]    lfsr_value;
    logic [LEN_WIDTH-1:0] idx_inc;
    logic                 last_pkt;

    eth_lfsr8 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .seed    (cfg_seed),
        .advance (lfsr_adv),
        .value   (lfsr_value)
    );

    assign mode_in  = (cfg_mode == MODE_FIXED || cfg_mode == MODE_LFSR) ? cfg_mode : MODE_INC;
    assign idx_inc  = idx_q + LEN_WIDTH'(1);
    assign last_pkt = (count_q != '0) && (sent_q + CNT_WIDTH'(1) == count_q);

    // Next-state and next-output logic; every output is taken from a register
    always_comb begin
        state_n   = state_q;
        data_n    = data_q;
        valid_n   = valid_q;
        sop_n     = sop_q;
        eop_n     = eop_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        sent_n    = sent_q;
        count_n   = count_q;
        idx_n     = idx_q;
        len_n     = len_q;
        gap_n     = gap_q;
        gap_cnt_n = gap_cnt_q;
        mode_n    = mode_q;
        seed_n    = seed_q;
        abort_n   = abort_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && cfg_len == '0) begin
                    err_n = 1'b1;
                end else if (start) begin
                    len_n     = cfg_len;
                    count_n   = cfg_count;
                    gap_n     = cfg_gap;
                    mode_n    = mode_in;
                    seed_n    = cfg_seed;
                    sent_n    = '0;
                    idx_n     = '0;
                    abort_n   = 1'b0;
                    lfsr_load = 1'b1;
                    state_n   = SEND;
                    busy_n    = 1'b1;
                    valid_n   = 1'b1;
                    sop_n     = 1'b1;
                    eop_n     = (cfg_len == LEN_WIDTH'(1));
                    data_n    = (mode_in == MODE_LFSR) ? lfsr_seed(cfg_seed) : cfg_seed;
                end
            end
            SEND: begin
                if (abort) abort_n = 1'b1;
                if (tx.tx_ready) begin
                    lfsr_adv = (mode_q == MODE_LFSR);
                    if (eop_q) begin
                        sent_n = sent_q + CNT_WIDTH'(1);
                        idx_n  = '0;
                        if (last_pkt || abort_q || abort) begin
                            state_n = DONE;
                            valid_n = 1'b0;
                            sop_n   = 1'b0;
                            eop_n   = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else if (gap_q != '0) begin
                            state_n   = GAP;
                            valid_n   = 1'b0;
                            sop_n     = 1'b0;
                            eop_n     = 1'b0;
                            gap_cnt_n = gap_q;
                        end else begin
                            sop_n  = 1'b1;
                            eop_n  = (len_q == LEN_WIDTH'(1));
                            data_n = (mode_q == MODE_LFSR) ? lfsr_next(lfsr_value) : seed_q;
                        end
                    end else begin
                        idx_n = idx_inc;
                        sop_n = 1'b0;
                        eop_n = (idx_inc == len_q - LEN_WIDTH'(1));
                        case (mode_q)
                            MODE_FIXED: data_n = seed_q;
                            MODE_LFSR:  data_n = lfsr_next(lfsr_value);
                            default:    data_n = seed_q + BYTE_W'(idx_inc);
                        endcase
                    end
                end
            end
            GAP: begin
                if (abort || abort_q) begin
                    abort_n = 1'b1;
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    // LFSR already advanced on the eop transfer, so its value is the next byte
                    state_n = SEND;
                    valid_n = 1'b1;
                    sop_n   = 1'b1;
                    eop_n   = (len_q == LEN_WIDTH'(1));
                    data_n  = (mode_q == MODE_LFSR) ? lfsr_value : seed_q;
                end else begin
                    gap_cnt_n = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sent_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            mode_q    <= MODE_INC;
            seed_q    <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            sop_q     <= sop_n;
            eop_q     <= eop_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            err_q     <= err_n;
            sent_q    <= sent_n;
            count_q   <= count_n;
            idx_q     <= idx_n;
            len_q     <= len_n;
            gap_q     <= gap_n;
            gap_cnt_q <= gap_cnt_n;
            mode_q    <= mode_n;
            seed_q    <= seed_n;
            abort_q   <= abort_n;
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign tx.tx_sop   = sop_q;
    assign tx.tx_eop   = eop_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_error   = err_q;
    assign pkt_sent    = sent_q;

endmodule

// File: tb/tb_eth_packet_source.sv
// Directed self-checking bench for eth_packet_source.
module tb_eth_packet_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] cfg_len;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_gap;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_seed;
    logic        busy;
    logic        done;
    logic        cfg_error;
    logic [15:0] pkt_sent;

    int total = 0;
    int bad   = 0;

    logic [7:0]  cap_data [64];
    logic        cap_sop  [64];
    logic        cap_eop  [64];
    int          cap_cyc  [64];
    int          n_beats;
    int          done_cyc;
    int          stall_err;
    logic        busy_at_done;
    logic [15:0] sent_at_done;

    eth_packet_source_if tx ();

    eth_packet_source dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .cfg_count (cfg_count),
        .cfg_gap   (cfg_gap),
        .cfg_mode  (cfg_mode),
        .cfg_seed  (cfg_seed),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .cfg_error (cfg_error),
        .pkt_sent  (pkt_sent)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one run, then record every transfer, stall stability and the done pulse
    task automatic run(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap,
                       input logic [1:0] mode, input logic [7:0] seed,
                       input bit stall, input int abort_after);
        logic [7:0] hd;
        logic       hs, he;
        bit         held;
        n_beats   = 0;
        done_cyc  = -1;
        stall_err = 0;
        held      = 0;
        hd = '0; hs = 1'b0; he = 1'b0;
        busy_at_done = 1'b1;
        sent_at_done = '1;
        cfg_len = len; cfg_count = cnt; cfg_gap = gap; cfg_mode = mode; cfg_seed = seed;
        start = 1'b1;
        tick;
        start = 1'b0;
        cfg_len = 16'd7; cfg_count = 16'd1; cfg_gap = 8'd0; cfg_mode = 2'b01; cfg_seed = 8'hEE;
        for (int i = 0; i < 300; i++) begin
            abort = 1'b0;
            tx.tx_ready = stall ? (i % 3 == 0) : 1'b1;
            if (held && (tx.tx_valid !== 1'b1 || tx.tx_data !== hd ||
                         tx.tx_sop !== hs || tx.tx_eop !== he))
                stall_err++;
            held = 0;
            if (done === 1'b1) begin
                done_cyc     = i;
                busy_at_done = busy;
                sent_at_done = pkt_sent;
                break;
            end
            if (tx.tx_valid === 1'b1 && tx.tx_ready === 1'b1) begin
                if (n_beats < 64) begin
                    cap_data[n_beats] = tx.tx_data;
                    cap_sop[n_beats]  = tx.tx_sop;
                    cap_eop[n_beats]  = tx.tx_eop;
                    cap_cyc[n_beats]  = i;
                end
                n_beats++;
                if (n_beats == abort_after) abort = 1'b1;
            end else if (tx.tx_valid === 1'b1) begin
                held = 1;
                hd = tx.tx_data; hs = tx.tx_sop; he = tx.tx_eop;
            end
            start = (i == 2);
            tick;
        end
        start = 1'b0;
        abort = 1'b0;
        tx.tx_ready = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx.tx_ready = 1'b1;
        cfg_len = '0; cfg_count = '0; cfg_gap = '0; cfg_mode = '0; cfg_seed = '0;
        tick; tick;
        total++;
        if ({tx.tx_data, tx.tx_valid, tx.tx_sop, tx.tx_eop, busy, done, cfg_error, pkt_sent} !== 30'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h/%b%b%b busy=%b done=%b err=%b sent=%0d want all 0",
                     tx.tx_data, tx.tx_valid, tx.tx_sop, tx.tx_eop, busy, done, cfg_error, pkt_sent);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_increment;
        logic [7:0] ed;
        run(16'd4, 16'd2, 8'd0, 2'b00, 8'h10, 1'b0, -1);
        total++;
        if (n_beats !== 8) begin bad++; $display("FAIL inc_beats: got %0d want 8", n_beats); end
        for (int j = 0; j < 8; j++) begin
            ed = 8'h10 + 8'(j % 4);
            total++;
            if ({cap_data[j], cap_sop[j], cap_eop[j]} !== {ed, (j % 4 == 0), (j % 4 == 3)} || cap_cyc[j] !== j) begin
                bad++;
                $display("FAIL inc_beat%0d: got data=%h sop=%b eop=%b cyc=%0d want data=%h sop=%b eop=%b cyc=%0d",
                         j, cap_data[j], cap_sop[j], cap_eop[j], cap_cyc[j], ed, (j % 4 == 0), (j % 4 == 3), j);
            end
        end
        total++;
        if (done_cyc !== 8 || sent_at_done !== 16'd2 || busy_at_done !== 1'b0) begin
            bad++;
            $display("FAIL inc_done: got cyc=%0d sent=%0d busy=%b want cyc=8 sent=2 busy=0",
                     done_cyc, sent_at_done, busy_at_done);
        end
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || tx.tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL inc_idle_after: got done=%b busy=%b valid=%b want 0 0 0", done, busy, tx.tx_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] ed;
        run(16'd4, 16'd2, 8'd0, 2'b00, 8'h10, 1'b1, -1);
        total++;
        if (n_beats !== 8 || stall_err !== 0) begin
            bad++;
            $display("FAIL bp_count_stable: got beats=%0d unstable=%0d want 8 0", n_beats, stall_err);
        end
        for (int j = 0; j < 8; j++) begin
            ed = 8'h10 + 8'(j % 4);
            total++;
            if ({cap_data[j], cap_sop[j], cap_eop[j]} !== {ed, (j % 4 == 0), (j % 4 == 3)} || cap_cyc[j] !== 3 * j) begin
                bad++;
                $display("FAIL bp_beat%0d: got data=%h sop=%b eop=%b cyc=%0d want data=%h sop=%b eop=%b cyc=%0d",
                         j, cap_data[j], cap_sop[j], cap_eop[j], cap_cyc[j], ed, (j % 4 == 0), (j % 4 == 3), 3 * j);
            end
        end
        total++;
        if (done_cyc !== 22 || sent_at_done !== 16'd2) begin
            bad++;
            $display("FAIL bp_done: got cyc=%0d sent=%0d want cyc=22 sent=2", done_cyc, sent_at_done);
        end
    endtask

    task automatic test_gap;
        int ec [6];
        ec[0] = 0; ec[1] = 1; ec[2] = 5; ec[3] = 6; ec[4] = 10; ec[5] = 11;
        run(16'd2, 16'd3, 8'd3, 2'b00, 8'h40, 1'b0, -1);
        total++;
        if (n_beats !== 6) begin bad++; $display("FAIL gap_beats: got %0d want 6", n_beats); end
        for (int j = 0; j < 6; j++) begin
            total++;
            if (cap_cyc[j] !== ec[j] || cap_data[j] !== 8'h40 + 8'(j % 2) || cap_sop[j] !== (j % 2 == 0)) begin
                bad++;
                $display("FAIL gap_beat%0d: got cyc=%0d data=%h sop=%b want cyc=%0d data=%h sop=%b",
                         j, cap_cyc[j], cap_data[j], cap_sop[j], ec[j], 8'h40 + 8'(j % 2), (j % 2 == 0));
            end
        end
        total++;
        if (done_cyc !== 12 || sent_at_done !== 16'd3) begin
            bad++;
            $display("FAIL gap_done: got cyc=%0d sent=%0d want cyc=12 sent=3", done_cyc, sent_at_done);
        end
    endtask

    task automatic test_fixed_len1;
        run(16'd1, 16'd2, 8'd0, 2'b01, 8'hA5, 1'b0, -1);
        total++;
        if (n_beats !== 2 || done_cyc !== 2) begin
            bad++;
            $display("FAIL fix_count: got beats=%0d done_cyc=%0d want 2 2", n_beats, done_cyc);
        end
        for (int j = 0; j < 2; j++) begin
            total++;
            if ({cap_data[j], cap_sop[j], cap_eop[j]} !== {8'hA5, 1'b1, 1'b1} || cap_cyc[j] !== j) begin
                bad++;
                $display("FAIL fix_beat%0d: got data=%h sop=%b eop=%b cyc=%0d want A5 1 1 %0d",
                         j, cap_data[j], cap_sop[j], cap_eop[j], cap_cyc[j], j);
            end
        end
    endtask

    task automatic test_lfsr_abort;
        logic [7:0] ed [6];
        int         ec [6];
        ed[0] = 8'h01; ed[1] = 8'h02; ed[2] = 8'h04; ed[3] = 8'h08; ed[4] = 8'h11; ed[5] = 8'h23;
        ec[0] = 0; ec[1] = 1; ec[2] = 2; ec[3] = 5; ec[4] = 6; ec[5] = 7;
        run(16'd3, 16'd0, 8'd2, 2'b10, 8'h00, 1'b0, 4);
        total++;
        if (n_beats !== 6) begin bad++; $display("FAIL lfsr_beats: got %0d want 6", n_beats); end
        for (int j = 0; j < 6; j++) begin
            total++;
            if ({cap_data[j], cap_sop[j], cap_eop[j]} !== {ed[j], (j % 3 == 0), (j % 3 == 2)} || cap_cyc[j] !== ec[j]) begin
                bad++;
                $display("FAIL lfsr_beat%0d: got data=%h sop=%b eop=%b cyc=%0d want data=%h sop=%b eop=%b cyc=%0d",
                         j, cap_data[j], cap_sop[j], cap_eop[j], cap_cyc[j], ed[j], (j % 3 == 0), (j % 3 == 2), ec[j]);
            end
        end
        total++;
        if (done_cyc !== 8 || sent_at_done !== 16'd2) begin
            bad++;
            $display("FAIL lfsr_abort_done: got cyc=%0d sent=%0d want cyc=8 sent=2", done_cyc, sent_at_done);
        end
    endtask

    task automatic test_cfg_error;
        cfg_len = 16'd0; cfg_count = 16'd1; cfg_gap = 8'd0; cfg_mode = 2'b00; cfg_seed = 8'h00;
        start = 1'b1;
        tick;
        start = 1'b0;
        total++;
        if (cfg_error !== 1'b1 || busy !== 1'b0 || tx.tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse: got err=%b busy=%b valid=%b want 1 0 0", cfg_error, busy, tx.tx_valid);
        end
        tick;
        total++;
        if (cfg_error !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got err=%b busy=%b want 0 0", cfg_error, busy);
        end
    endtask

    task automatic test_reset_mid_packet;
        cfg_len = 16'd8; cfg_count = 16'd1; cfg_gap = 8'd0; cfg_mode = 2'b00; cfg_seed = 8'h30;
        tx.tx_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        total++;
        if (tx.tx_valid !== 1'b1 || tx.tx_data !== 8'h32 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: got valid=%b data=%h busy=%b want 1 32 1", tx.tx_valid, tx.tx_data, busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({tx.tx_data, tx.tx_valid, tx.tx_sop, tx.tx_eop, busy, done, cfg_error, pkt_sent} !== 30'd0) begin
            bad++;
            $display("FAIL rst_async: got data=%h valid=%b busy=%b sent=%0d want all 0",
                     tx.tx_data, tx.tx_valid, busy, pkt_sent);
        end
        tick;
        rst_n = 1'b1;
        tick;
        total++;
        if (tx.tx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle: got valid=%b busy=%b want 0 0", tx.tx_valid, busy);
        end
        cfg_len = 16'd1; cfg_seed = 8'h30;
        start = 1'b1;
        tick;
        start = 1'b0;
        total++;
        if ({tx.tx_valid, tx.tx_sop, tx.tx_eop, tx.tx_data} !== {3'b111, 8'h30}) begin
            bad++;
            $display("FAIL rst_restart: got valid=%b sop=%b eop=%b data=%h want 1 1 1 30",
                     tx.tx_valid, tx.tx_sop, tx.tx_eop, tx.tx_data);
        end
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_increment;
        test_backpressure;
        test_gap;
        test_fixed_len1;
        test_lfsr_abort;
        test_cfg_error;
        test_reset_mid_packet;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
